decoder_nto2n_scan: RTL and testbench
=====================================

# decoder_nto2n_scan

Parametrised, registered N-to-2^N one-hot decoder with enable, programmable active level and a built-in scan mode. In direct mode it decodes an external select. In scan mode it steps its own select through outputs 0..LAST, holding each for DWELL cycles. It drives digit/row strobes for multiplexed displays and keypads, replacing fixed 2-to-4 enable decoders in new designs.

## Interface
- N, default 2: select width; output width is 2^N (N ≥ 1).
- DWELL, default 4: clock cycles each index is held in scan mode (DWELL ≥ 1).
- LAST, default 2^N-1: highest index visited in scan mode (0 ≤ LAST ≤ 2^N-1).
- ACTIVE_LOW, default 0: 1 = asserted output bit is 0 and inactive bits are 1.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  1 = decode/scan; 0 = all outputs inactive and the scan is paused.
- mode  input  1  0 = direct (decode w); 1 = scan (internal counter).
- w  input  N  select in direct mode; ignored in scan mode.
- y  output  2^N  registered one-hot (or one-cold) strobe.
- sel  output  N  registered index currently driven; always consistent with y.
- wrap  output  1  one-cycle pulse when the scan steps from LAST back to 0.

## Operation
- Reset (rst_n=0, asynchronous): sel=0, dwell counter=0, wrap=0, y=all-inactive (all 0, or all 1 if ACTIVE_LOW). Reset applies immediately, including mid-scan. The first update after release occurs on the first rising edge with rst_n=1.
- Each cycle computes sel_d, then registers sel<=sel_d and y<= en ? decode(sel_d) : inactive.
- Direct (mode=0): sel_d=w; dwell counter cleared to 0; wrap=0. Any w value in 0..2^N-1 decodes, including values above LAST.
- Scan (mode=1), en=1:
  - If dwell < DWELL-1: dwell+1; sel_d=sel.
  - If dwell = DWELL-1: dwell=0; sel_d = (sel ≥ LAST) ? 0 : sel+1. wrap=1 for that one cycle if sel ≥ LAST.
- Scan, en=0: sel and dwell hold (pause); y inactive; wrap=0. When en returns to 1, counting resumes from the held dwell value.
- Mode 0→1: the scan starts at the current sel (the last decoded w) with dwell=0. If that sel > LAST, it wraps to 0 at the end of its dwell, with a wrap pulse.
- Mode 1→0: the next cycle decodes w; dwell is cleared.
- DWELL=1: the index advances every enabled cycle. LAST=0: sel stays 0 and wrap pulses every DWELL cycles.
- Dwell counter width is max(1, clog2(DWELL)). The sel increment is N-bit and never overflows, because the wrap check precedes it.

## Timing
- Direct latency: 1 cycle, i.e. w/en sampled at edge k are reflected in y/sel after edge k.
- In scan mode each index is visible for exactly DWELL consecutive enabled cycles. A full sweep is (LAST+1)·DWELL enabled cycles.
- wrap is asserted in the same cycle that sel/y first show index 0 after the wrap.
- All outputs are registered, so y has no combinational glitches.
- Exactly one y bit is active whenever en was 1 at the last edge; none is active otherwise.

## Structure
- Shared package/header `decoder_pkg`:
  - function onehot(idx, N);
  - the inactive-level constant derived from ACTIVE_LOW;
  - the clog2 helper.
- Sub-module `decoder_nto2n` (combinational, parametrised N, active-high one-hot):
  - instantiated once on sel_d;
  - polarity inversion and registering are done in the top.
- Parameter-legality checks (N, DWELL, LAST) are elaboration-time assertions in the top.

## Test plan
N=2, DWELL=3, LAST=2, ACTIVE_LOW=0 unless stated.
- Reset: hold rst_n=0 with en=1, mode=0, w=2 → y=0000, sel=0, wrap=0. Release → next edge gives y=0100, sel=2.
- Direct sweep: en=1, mode=0, w=0,1,2,3 on successive edges → y=0001,0010,0100,1000, each one cycle after its w. Drop en=0 → y=0000 next cycle.
- Scan: mode=1 from sel=0 → y=0001 ×3 cycles, 0010 ×3, 0100 ×3, then 0001 with wrap=1 for exactly one cycle; index 3 never appears.
- Pause/resume: in scan, drop en for 5 cycles one cycle into index 1 → y=0000 and sel=1 held. Raise en → 0010 remains for the 2 remaining dwell cycles, then 0100.
- Entry above LAST: direct w=3 (y=1000), then mode=1 → 1000 ×3 cycles, then 0001 with wrap=1. Repeat with ACTIVE_LOW=1 → the same sequence inverted (0111, then 1110).
- Async reset mid-scan: assert rst_n between clock edges during index 2 → y=0000 and sel=0 immediately, without waiting for a clock edge. After release in scan mode, the sweep restarts at index 0 with a full 3-cycle dwell.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared helpers for the N-to-2^N decoder family: one-hot encode, inactive level, clog2.
package decoder_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  typedef logic [MAX_W-1:0] wide_t;

  // Callers truncate the result to 2^n bits; out-of-range indices give all zero.
  function automatic wide_t onehot(input int unsigned idx, input int unsigned n);
    if (idx >= (32'd1 << n)) return '0;
    return wide_t'(1) << idx;
  endfunction

  function automatic logic inactive_level(input int active_low);
    return (active_low != 0);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/decoder_nto2n_scan_if.sv
// Select inputs and strobe outputs of the scanning decoder.
interface decoder_nto2n_scan_if #(parameter int N = 2);

  logic                en;
  logic                mode;
  logic [N-1:0]        w;
  logic [(1<<N)-1:0]   y;
  logic [N-1:0]        sel;
  logic                wrap;

  modport master (output en, mode, w, input y, sel, wrap);
  modport slave  (input en, mode, w, output y, sel, wrap);

endinterface

// File: rtl/decoder_nto2n.sv
// Combinational active-high N-to-2^N one-hot decoder.
// Latency: 0 cycles. Backpressure: none.
module decoder_nto2n
  import decoder_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]      idx,
  output logic [(1<<N)-1:0] dec
);

  localparam int W = 1 << N;

  assign dec = W'(onehot(32'(idx), N));

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N strobe decoder with direct and self-scanning modes.
// Latency: 1 cycle from en/mode/w to y/sel/wrap.
// Backpressure: none; outputs are free-running strobes.
module decoder_nto2n_scan
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter int LAST       = (1 << N) - 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decoder_nto2n_scan_if.slave    bus
);

  localparam int               W         = 1 << N;
  localparam int               DW        = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [DW-1:0]    DWELL_MAX = DW'(DWELL - 1);
  localparam logic [N-1:0]     LAST_SEL  = N'(LAST);
  localparam logic             INACTIVE  = inactive_level(ACTIVE_LOW);

  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("decoder_nto2n_scan: N out of range");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("decoder_nto2n_scan: DWELL must be at least 1");
  end
  if (LAST < 0 || LAST > W - 1) begin : g_bad_last
    $error("decoder_nto2n_scan: LAST out of range");
  end

  logic [N-1:0]  sel_q, sel_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          wrap_q, wrap_d;
  logic [W-1:0]  y_q;
  logic [W-1:0]  dec;

  always_comb begin
    sel_d   = sel_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (!bus.mode) begin
      sel_d   = bus.w;
      dwell_d = '0;
    end else if (bus.en) begin
      if (dwell_q < DWELL_MAX) begin
        dwell_d = dwell_q + 1'b1;
      end else begin
        dwell_d = '0;
        // Wrap test first so sel never increments past 2^N-1, even when entered above LAST.
        if (sel_q >= LAST_SEL) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
    end
  end

  decoder_nto2n #(.N(N)) u_dec (
    .idx (sel_d),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      y_q     <= {W{INACTIVE}};
    end else begin
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      y_q     <= (bus.en ? dec : '0) ^ {W{INACTIVE}};
    end
  end

  assign bus.y    = y_q;
  assign bus.sel  = sel_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Directed bench: N=2, DWELL=3, LAST=2, with an ACTIVE_LOW twin fed the same inputs.
module tb_decoder_nto2n_scan;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decoder_nto2n_scan_if #(.N(2)) bus ();
  decoder_nto2n_scan_if #(.N(2)) bus_al ();

  assign bus_al.en   = bus.en;
  assign bus_al.mode = bus.mode;
  assign bus_al.w    = bus.w;

  decoder_nto2n_scan #(.N(2), .DWELL(3), .LAST(2), .ACTIVE_LOW(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decoder_nto2n_scan #(.N(2), .DWELL(3), .LAST(2), .ACTIVE_LOW(1)) dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] ey, input logic [1:0] es, input logic ew);
    checks++;
    assert (bus.y === ey) else begin
      errors++;
      $error("FAIL %s y: observed %b expected %b", tag, bus.y, ey);
    end
    checks++;
    assert (bus.sel === es) else begin
      errors++;
      $error("FAIL %s sel: observed %0d expected %0d", tag, bus.sel, es);
    end
    checks++;
    assert (bus.wrap === ew) else begin
      errors++;
      $error("FAIL %s wrap: observed %b expected %b", tag, bus.wrap, ew);
    end
    checks++;
    assert (bus_al.y === ~ey) else begin
      errors++;
      $error("FAIL %s y_al: observed %b expected %b", tag, bus_al.y, ~ey);
    end
    checks++;
    assert (bus_al.sel === es && bus_al.wrap === ew) else begin
      errors++;
      $error("FAIL %s al sel/wrap: observed %0d/%b expected %0d/%b",
             tag, bus_al.sel, bus_al.wrap, es, ew);
    end
  endtask

  // Scan sweep after entering scan from a direct decode of w=0.
  logic [1:0] scan_sel [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};

  initial begin
    logic [3:0] e;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    bus.w    = 2'd2;

    repeat (2) tick();
    chk("reset", 4'b0000, 2'd0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("release", 4'b0100, 2'd2, 1'b0);

    for (int i = 0; i < 4; i++) begin
      bus.w = 2'(i);
      tick();
      e = 4'b0001 << i;
      chk("direct", e, 2'(i), 1'b0);
    end
    bus.en = 1'b0;
    tick();
    chk("direct_en0", 4'b0000, 2'd3, 1'b0);

    bus.en = 1'b1;
    bus.w  = 2'd0;
    tick();
    chk("scan_pre", 4'b0001, 2'd0, 1'b0);
    bus.mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      e = 4'b0001 << scan_sel[k];
      chk("scan", e, scan_sel[k], (k == 8) ? 1'b1 : 1'b0);
    end

    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pause", 4'b0000, 2'd1, 1'b0);
    end
    bus.en = 1'b1;
    tick();
    chk("resume1", 4'b0010, 2'd1, 1'b0);
    tick();
    chk("resume2", 4'b0010, 2'd1, 1'b0);
    tick();
    chk("resume3", 4'b0100, 2'd2, 1'b0);

    // Between edges during index 2: outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 2'd0, 1'b0);
    #3 rst_n = 1'b1;
    // The reset state itself is dwell 0 of index 0.
    tick();
    chk("post_rst1", 4'b0001, 2'd0, 1'b0);
    tick();
    chk("post_rst2", 4'b0001, 2'd0, 1'b0);
    tick();
    chk("post_rst3", 4'b0010, 2'd1, 1'b0);

    bus.mode = 1'b0;
    bus.w    = 2'd3;
    tick();
    chk("above_direct", 4'b1000, 2'd3, 1'b0);
    bus.mode = 1'b1;
    tick();
    chk("above1", 4'b1000, 2'd3, 1'b0);
    tick();
    chk("above2", 4'b1000, 2'd3, 1'b0);
    tick();
    chk("above_wrap", 4'b0001, 2'd0, 1'b1);
    tick();
    chk("above_after", 4'b0001, 2'd0, 1'b0);

    bus.mode = 1'b0;
    bus.w    = 2'd1;
    tick();
    chk("back_direct", 4'b0010, 2'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
